// File: rtl/gpio_pkg.sv
// Shared definitions for the minisoc GPIO controller: register decode
// indices and the byte-strobe expansion helper.
package gpio_pkg;

  localparam int GPIO_DECODE_W = 3;

  // Word indices taken from addr[4:2]; indices 6 and 7 are reserved.
  localparam logic [GPIO_DECODE_W-1:0] GPIO_DATA_IN    = 3'd0;
  localparam logic [GPIO_DECODE_W-1:0] GPIO_DATA_OUT   = 3'd1;
  localparam logic [GPIO_DECODE_W-1:0] GPIO_DIR        = 3'd2;
  localparam logic [GPIO_DECODE_W-1:0] GPIO_IRQ_EN     = 3'd3;
  localparam logic [GPIO_DECODE_W-1:0] GPIO_IRQ_EDGE   = 3'd4;
  localparam logic [GPIO_DECODE_W-1:0] GPIO_IRQ_STATUS = 3'd5;

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    strb_mask = '0;
    for (int k = 0; k < 4; k++) begin
      strb_mask[8*k +: 8] = {8{strb[k]}};
    end
  endfunction

endpackage

// File: rtl/gpio_if.sv
// minisoc peripheral-bus port bundle for the GPIO controller.
// The core side drives the request fields; the controller answers.
interface gpio_if #(
  parameter int AW = 12,
  parameter int DW = 32
);
  logic            gpio_req;
  logic            gpio_write;
  logic [DW/8-1:0] gpio_wstrb;
  logic [AW-1:0]   gpio_addr;
  logic [DW-1:0]   gpio_wdata;
  logic            gpio_addr_ok;
  logic            gpio_data_ok;
  logic [DW-1:0]   gpio_rdata;
  logic            gpio_irq;

  modport master (
    output gpio_req, gpio_write, gpio_wstrb, gpio_addr, gpio_wdata,
    input  gpio_addr_ok, gpio_data_ok, gpio_rdata, gpio_irq
  );

  modport slave (
    input  gpio_req, gpio_write, gpio_wstrb, gpio_addr, gpio_wdata,
    output gpio_addr_ok, gpio_data_ok, gpio_rdata, gpio_irq
  );
endinterface

// File: rtl/gpio_sync.sv
// Two-flop synchroniser for asynchronous pad inputs; each bit is
// treated independently, so multi-bit values are not coherent.
module gpio_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  // NOTE: non-blocking assignments let both flops sample their inputs from
  // before the edge; blocking ones would collapse the chain into one stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO controller: per-pin direction/output registers,
// synchronised inputs, edge-detect interrupts and a one-cycle bus response.
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AW    = 12,
  parameter int DW    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  gpio_if.slave            bus,
  inout  wire  [WIDTH-1:0] GPIO
);

  logic [WIDTH-1:0] dout_q, dir_q, irq_en_q, irq_edge_q, irq_status_q;
  logic [WIDTH-1:0] sync_q, prev_q;
  logic [WIDTH-1:0] rise, fall, pin_evt, clr_mask, status_nxt;
  logic [WIDTH-1:0] wmask, wdata_w;
  logic [31:0]      mask_full;
  logic [GPIO_DECODE_W-1:0] idx;
  logic             wr_en, rd_en;
  logic             data_ok_q;
  logic [DW-1:0]    rdata_q, rd_val;
  logic             unused_bits;

  assign idx       = bus.gpio_addr[GPIO_DECODE_W+1:2];
  assign wr_en     = bus.gpio_req & bus.gpio_write;
  assign rd_en     = bus.gpio_req & ~bus.gpio_write;
  assign mask_full = strb_mask(bus.gpio_wstrb);
  assign wmask     = mask_full[WIDTH-1:0];
  assign wdata_w   = bus.gpio_wdata[WIDTH-1:0];

  // Address bits outside [4:2] and data bits above WIDTH are don't-care.
  assign unused_bits = ^{bus.gpio_addr, bus.gpio_wdata, mask_full};

  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign GPIO[i] = dir_q[i] ? dout_q[i] : 1'bz;
  end

  // Driven pins are sampled too, so outputs loop back into DATA_IN and events.
  gpio_sync #(.WIDTH(WIDTH)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (GPIO),
    .q     (sync_q)
  );

  assign rise    = sync_q & ~prev_q;
  assign fall    = ~sync_q & prev_q;
  assign pin_evt = (irq_edge_q & rise) | (~irq_edge_q & fall);

  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    clr_mask = '0;
    if (wr_en && idx == GPIO_IRQ_STATUS) clr_mask = wdata_w & wmask;
    // OR-ing the event in last makes a same-cycle set win over the clear.
    status_nxt = (irq_status_q & ~clr_mask) | pin_evt;
  end

  always_comb begin
    rd_val = '0;
    case (idx)
      GPIO_DATA_IN:    rd_val[WIDTH-1:0] = sync_q;
      GPIO_DATA_OUT:   rd_val[WIDTH-1:0] = dout_q;
      GPIO_DIR:        rd_val[WIDTH-1:0] = dir_q;
      GPIO_IRQ_EN:     rd_val[WIDTH-1:0] = irq_en_q;
      GPIO_IRQ_EDGE:   rd_val[WIDTH-1:0] = irq_edge_q;
      GPIO_IRQ_STATUS: rd_val[WIDTH-1:0] = irq_status_q;
      default:         rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q       <= '0;
      dir_q        <= '0;
      irq_en_q     <= '0;
      irq_edge_q   <= '0;
      irq_status_q <= '0;
      prev_q       <= '0;
      data_ok_q    <= 1'b0;
      rdata_q      <= '0;
    end else begin
      prev_q       <= sync_q;
      irq_status_q <= status_nxt;
      data_ok_q    <= bus.gpio_req;
      if (rd_en) rdata_q <= rd_val;
      if (wr_en) begin
        case (idx)
          GPIO_DATA_OUT: dout_q     <= (dout_q     & ~wmask) | (wdata_w & wmask);
          GPIO_DIR:      dir_q      <= (dir_q      & ~wmask) | (wdata_w & wmask);
          GPIO_IRQ_EN:   irq_en_q   <= (irq_en_q   & ~wmask) | (wdata_w & wmask);
          GPIO_IRQ_EDGE: irq_edge_q <= (irq_edge_q & ~wmask) | (wdata_w & wmask);
          default: ;
        endcase
      end
    end
  end

  assign bus.gpio_addr_ok = 1'b1;
  assign bus.gpio_data_ok = data_ok_q;
  assign bus.gpio_rdata   = rdata_q;
  assign bus.gpio_irq     = |(irq_status_q & irq_en_q);

endmodule
